ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Arbitrates boot loader, CPU data and CPU fetch onto one synchronous-read RAM port.
// Grants are combinational; read data returns one cycle after the grant to whichever port issued the read.
module ram_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_active,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]    starve_q, starve_d;
  owner_e        owner_q, owner_d;
  logic [DW-1:0] d_rdata_q, f_rdata_q;

  always_comb begin
    b_gnt = 1'b0;
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    if (!rst) begin
      if (boot_active) begin
        b_gnt = b_req;
      end else if (f_req && (starve_q >= LIMIT || !d_req)) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_en    = b_gnt | d_gnt | f_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (b_gnt) begin
      ram_we    = 1'b1;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end else if (d_gnt) begin
      ram_we    = d_we;
      ram_addr  = d_addr;
      ram_wdata = d_we ? d_wdata : '0;
    end else if (f_gnt) begin
      ram_addr  = f_addr;
    end
  end

  // Counter only advances while fetch is actually being passed over by data.
  always_comb begin
    starve_d = starve_q;
    if (f_gnt || !f_req) begin
      starve_d = '0;
    end else if (d_gnt && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end else if (f_gnt) begin
      owner_d = OWN_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      owner_q   <= OWN_NONE;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      if (owner_q == OWN_DATA) begin
        d_rdata_q <= ram_rdata;
      end
      if (owner_q == OWN_FETCH) begin
        f_rdata_q <= ram_rdata;
      end
    end
  end

  // A reset arriving while a read is in flight suppresses its return.
  assign d_rvalid = (owner_q == OWN_DATA) && !rst;
  assign f_rvalid = (owner_q == OWN_FETCH) && !rst;
  assign d_rdata  = d_rvalid ? ram_rdata : d_rdata_q;
  assign f_rdata  = f_rvalid ? ram_rdata : f_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a read-response scoreboard.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_active;
  logic          b_req, b_gnt;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .boot_active(boot_active),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    bit            port;   // 0 = data, 1 = fetch
    logic [DW-1:0] dat;
    int            cyc;
  } rsp_t;
  rsp_t sbq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [DW-1:0] last_d = '0;
  logic [DW-1:0] last_f = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Read-response monitor: pops the scoreboard whenever either port shows rvalid.
  always @(negedge clk) begin
    rsp_t r;
    if (d_rvalid || f_rvalid) begin
      if (sbq.size() == 0) begin
        chk("spurious_rvalid", {30'd0, d_rvalid, f_rvalid}, 32'd0);
      end else begin
        r = sbq.pop_front();
        chk("rsp_cycle", cyc, r.cyc);
        chk("rvalid_port", {30'd0, d_rvalid, f_rvalid}, r.port ? 32'd1 : 32'd2);
        if (r.port) begin
          chk("f_rdata", {16'd0, f_rdata}, {16'd0, r.dat});
          chk("d_rdata_held", {16'd0, d_rdata}, {16'd0, last_d});
          last_f = r.dat;
        end else begin
          chk("d_rdata", {16'd0, d_rdata}, {16'd0, r.dat});
          chk("f_rdata_held", {16'd0, f_rdata}, {16'd0, last_f});
          last_d = r.dat;
        end
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      chk("missing_rvalid", {30'd0, d_rvalid, f_rvalid}, sbq[0].port ? 32'd1 : 32'd2);
      void'(sbq.pop_front());
    end
  end

  // One cycle: check grants {b,d,f} mid-cycle, optionally expect read data next cycle.
  task automatic step(input logic [2:0] eg, input logic [DW-1:0] edat, input bit rsp);
    rsp_t r;
    @(negedge clk);
    chk("grants", {29'd0, b_gnt, d_gnt, f_gnt}, {29'd0, eg});
    chk("ram_en", {31'd0, ram_en}, {31'd0, |eg});
    if (rsp && ((eg == 3'b010 && !d_we) || eg == 3'b001)) begin
      r.port = (eg == 3'b001);
      r.dat  = edat;
      r.cyc  = cyc + 1;
      sbq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] fpat;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] fpat;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'hAAAA;
    mem[8'h11] = 16'h5555;
    ram_rdata = '0;
    rst = 1'b1; boot_active = 1'b0;
    b_req = 1'b1; b_addr = '0; b_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_wdata = '0;
    f_req = 1'b1; f_addr = 8'h11;
    #1;

    // Reset held two cycles with every request high.
    step(3'b000, '0, 0);
    #2;
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
    chk("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    chk("rst_f_rdata", {16'd0, f_rdata}, 32'd0);
    step(3'b000, '0, 0);

    // Starvation: D,D,D,D,F repeating; fetch wins in cycles 5 and 10.
    rst = 1'b0;
    fpat = 12'b0010_0001_0000;
    for (int i = 0; i < 12; i++)
      step(fpat[i] ? 3'b001 : 3'b010, fpat[i] ? 16'h5555 : 16'hAAAA, 1);

    // Alternating single-port reads return in order with no bubbles.
    for (int k = 0; k < 2; k++) begin
      d_req = 1'b1; f_req = 1'b0;
      step(3'b010, 16'hAAAA, 1);
      d_req = 1'b0; f_req = 1'b1;
      step(3'b001, 16'h5555, 1);
    end
    d_req = 1'b0; f_req = 1'b0;
    #2;
    chk("idle_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
    step(3'b000, '0, 0);

    // Boot load: only the boot port is served.
    boot_active = 1'b1; b_req = 1'b1; b_addr = 8'h05; b_wdata = 16'h1234;
    d_req = 1'b1; f_req = 1'b1; f_addr = 8'h05;
    #2;
    chk("boot_ram_we", {31'd0, ram_we}, 32'd1);
    chk("boot_ram_addr", {24'd0, ram_addr}, 32'h05);
    chk("boot_ram_wdata", {16'd0, ram_wdata}, 32'h1234);
    step(3'b100, '0, 0);
    b_req = 1'b0;
    step(3'b000, '0, 0);
    // boot_active drops while b_req is still up: fetch reads the booted word.
    boot_active = 1'b0; b_req = 1'b1; d_req = 1'b0;
    step(3'b001, 16'h1234, 1);

    // Data read outstanding while boot_active rises still returns.
    b_req = 1'b0; f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h11;
    step(3'b010, 16'h5555, 1);
    boot_active = 1'b1;
    step(3'b000, '0, 0);
    boot_active = 1'b0; d_req = 1'b0;

    // Write then read-after-write on the data port.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    #2;
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_wdata", {16'd0, ram_wdata}, 32'hBEEF);
    step(3'b010, '0, 0);
    d_we = 1'b0;
    step(3'b010, 16'hBEEF, 1);
    d_req = 1'b0;
    step(3'b000, '0, 0);

    // Reset lands while a fetch read is in flight.
    d_req = 1'b1; f_req = 1'b1; d_addr = 8'h10; f_addr = 8'h11;
    step(3'b010, 16'hAAAA, 1);
    d_req = 1'b0;
    step(3'b001, '0, 0);
    rst = 1'b1; d_req = 1'b1;
    #2;
    chk("midrst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
    step(3'b000, '0, 0);
    chk("midrst_starve", {28'd0, dut.starve_q}, 32'd0);
    chk("midrst_f_rdata", {16'd0, f_rdata}, 32'd0);
    chk("midrst_d_rdata", {16'd0, d_rdata}, 32'd0);
    last_d = '0; last_f = '0;
    rst = 1'b0; d_req = 1'b0; f_req = 1'b0;
    step(3'b000, '0, 0);
    step(3'b000, '0, 0);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
